// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : FWFT byte buffer feeding uart_tx (DEPTH memory + 1 output register)
// Revision: 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } out_state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mcnt_q, mcnt_d;
    out_state_t    state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          overflow_q, overflow_d;

    logic          w_wr_ok;
    logic          w_xfer;
    logic          w_refill;

    // All decisions use pre-edge state, so a write while full is dropped
    // even if the output register refills in the same edge.
    assign full     = (mcnt_q == C_DEPTH);
    assign w_wr_ok  = wr_en && !full;
    assign w_xfer   = (state_q == S_LOADED) && tx_ready;
    assign w_refill = (mcnt_q != '0) && ((state_q == S_EMPTY) || tx_ready);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mcnt_d     = mcnt_q;
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        overflow_d = wr_en && full;

        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({w_wr_ok, w_refill})
            2'b10:   mcnt_d = mcnt_q + 1'b1;
            2'b01:   mcnt_d = mcnt_q - 1'b1;
            default: mcnt_d = mcnt_q;
        endcase

        if (w_refill) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
            state_d   = S_LOADED;
        end else if (w_xfer) begin
            state_d   = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mcnt_q     <= '0;
            state_q    <= S_EMPTY;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mcnt_q     <= mcnt_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_valid = (state_q == S_LOADED);
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign empty    = (mcnt_q == '0) && !tx_valid;
    assign count    = mcnt_q + {{AW{1'b0}}, tx_valid};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Randomized and directed bench for uart_tx_fifo with a queue model
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of bytes waiting in memory plus the head byte.
    logic [7:0] memq [$];
    logic       m_hv;
    logic [7:0] m_hd;
    logic       m_ov;

    uart_tx_fifo #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic full_pre;
        logic xfer;
        if (!rst) begin
            memq.delete();
            m_hv = 1'b0;
            m_hd = 8'h00;
            m_ov = 1'b0;
        end else begin
            full_pre = (memq.size() == DEPTH);
            xfer     = m_hv && tx_ready;
            m_ov     = wr_en && full_pre;
            if ((!m_hv || xfer) && memq.size() > 0) begin
                m_hd = memq.pop_front();
                m_hv = 1'b1;
            end else if (xfer) begin
                m_hv = 1'b0;
            end
            if (wr_en && !full_pre) memq.push_back(wr_data);
        end
    endtask

    task automatic compare_all();
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_hv});
        if (m_hv) check("tx_data", {24'd0, tx_data}, {24'd0, m_hd});
        check("count", {27'd0, count}, memq.size() + (m_hv ? 1 : 0));
        check("full", {31'd0, full}, (memq.size() == DEPTH) ? 1 : 0);
        check("empty", {31'd0, empty}, (memq.size() == 0 && !m_hv) ? 1 : 0);
        check("overflow", {31'd0, overflow}, {31'd0, m_ov});
    endtask

    // Apply inputs, take one clock edge, then compare on the falling edge.
    task automatic cyc(input logic we, input logic [7:0] d, input logic rdy, input logic rn);
        wr_en    = we;
        wr_data  = d;
        tx_ready = rdy;
        rst      = rn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int rcv;
        int wn;
        logic saw_ov;
        logic we;
        logic rdy;

        wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b0; rst = 1'b0;
        m_hv = 1'b0; m_hd = 8'h00; m_ov = 1'b0;

        // Reset and first-write latency
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_tx_valid", {31'd0, tx_valid}, 0);
        check("rst_tx_data",  {24'd0, tx_data}, 32'h00);
        check("rst_empty",    {31'd0, empty}, 1);
        check("rst_count",    {27'd0, count}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        check("a5_not_yet", {31'd0, tx_valid}, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("a5_valid", {31'd0, tx_valid}, 1);
        check("a5_data",  {24'd0, tx_data}, 32'hA5);

        // Fill with stalled sink, then overflow
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
        check("fill_count", {27'd0, count}, 17);
        check("fill_full",  {31'd0, full}, 1);
        check("fill_head",  {24'd0, tx_data}, 32'h00);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        check("ovf_pulse", {31'd0, overflow}, 1);
        check("ovf_count", {27'd0, count}, 17);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", {31'd0, overflow}, 0);

        // Drain back-to-back
        for (int i = 0; i < 17; i++) begin
            check("drain_valid", {31'd0, tx_valid}, 1);
            check("drain_data",  {24'd0, tx_data}, i);
            cyc(1'b0, 8'h00, 1'b1, 1'b1);
        end
        check("drain_done_valid", {31'd0, tx_valid}, 0);
        check("drain_done_empty", {31'd0, empty}, 1);

        // Wrap-around with random interleaving of writes and accepts
        rcv = 0;
        wn  = 0;
        for (int c = 0; c < 600 && rcv < 40; c++) begin
            we  = (wn < 40) && !full && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (tx_valid && rdy) begin
                check("wrap_order", {24'd0, tx_data}, rcv);
                rcv++;
            end
            cyc(we, 8'(wn), rdy, 1'b1);
            if (we) wn++;
        end
        check("wrap_received", rcv, 40);

        // Sustained simultaneous write and accept
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("preload_count", {27'd0, count}, 3);
        saw_ov = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 8'($urandom), 1'b1, 1'b1);
            if (count != 3 || overflow) saw_ov = 1'b1;
        end
        check("simul_steady", {31'd0, saw_ov}, 0);

        // Reset while stalled mid-stream
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
        check("mid_pre_valid", {31'd0, tx_valid}, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("mid_rst_valid", {31'd0, tx_valid}, 0);
        check("mid_rst_count", {27'd0, count}, 0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("mid_first_out", {24'd0, tx_data}, 32'h3C);
        check("mid_first_vld", {31'd0, tx_valid}, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer placed directly upstream of `uart_tx`: a producer writes bytes at clock rate and the block holds them, presenting one byte at a time on the `tx_data`/`tx_valid` handshake and advancing only when `uart_tx` accepts via `tx_ready`. It decouples bursty producers from the slow serial transmitter. The output stage is first-word-fall-through (FWFT): the head byte is already valid on `tx_data` and is consumed in the accepting cycle.

## Interface
- `AW`, default 4: memory address width; memory depth `DEPTH = 2**AW` (16).
- `clk  in  1` – single system clock; all logic on rising edge.
- `rst  in  1` – synchronous, active-low reset.
- `wr_data  in  8` – byte to enqueue.
- `wr_en  in  1` – write request; sampled every edge.
- `full  out  1` – memory holds DEPTH bytes; writes are dropped.
- `empty  out  1` – memory and output register both empty.
- `count  out  AW+1` – total bytes held (memory + output register), 0..DEPTH+1.
- `overflow  out  1` – one-cycle pulse when a write is dropped.
- `tx_data  out  8` – head byte, to `uart_tx.tx_data`.
- `tx_valid  out  1` – `tx_data` holds a byte, to `uart_tx.tx_valid`.
- `tx_ready  in  1` – from `uart_tx.tx_ready`; transmitter accepts the byte.

## Operation
- Storage: DEPTH×8 memory array with `wr_ptr`/`rd_ptr` of AW bits and wrap modulo DEPTH, plus an 8-bit output register with a valid flag. Total capacity is DEPTH+1.
- Memory occupancy `mcnt` (AW+1 bits): `full = (mcnt == DEPTH)`; `empty = (mcnt == 0) && !tx_valid`; `count = mcnt + tx_valid`.
- Write:
  - When `wr_en && !full`: `mem[wr_ptr] <= wr_data`, `wr_ptr++`.
  - When `wr_en && full`: the byte is discarded, pointers are unchanged, and `overflow` is high for the next cycle only.
  - There is no bypass: a write always passes through memory.
- Handshake: the byte transfers on an edge where `tx_valid && tx_ready`.
  - While `tx_valid && !tx_ready`, `tx_data` and `tx_valid` hold stable.
  - `tx_valid` never drops without a transfer, except on reset.
- Output register states:
  - EMPTY (`tx_valid=0`): if `mcnt>0`, load `mem[rd_ptr]`, `rd_ptr++`, go to LOADED.
  - LOADED (`tx_valid=1`):
    - On transfer with `mcnt>0`: load the next byte, stay LOADED (back-to-back, no bubble).
    - On transfer with `mcnt==0`: go to EMPTY.
    - Without a transfer: hold.
- Simultaneous write and refill in one edge: `mcnt` is unchanged, and both pointers advance.
- Write while full and a refill in the same edge: the write is still dropped, because `full` is evaluated on pre-edge state.
- Reset (`rst==0` at an edge): pointers = 0, `mcnt` = 0, `tx_valid` = 0, `tx_data` = 8'h00, `overflow` = 0. All contents are discarded even mid-stream.
- Reset values seen at outputs: `full`=0, `empty`=1, `count`=0.
- The memory array is not reset.

## Timing
- Write latency: `wr_en` at edge k into an empty block → `tx_valid=1` with `tx_data=wr_data` after edge k+1 (2-cycle latency).
- Refill after transfer: transfer at edge k with `mcnt>0` → new byte valid immediately after edge k, so consecutive bytes are available on consecutive cycles.
- `full`, `empty` and `count` update on the same edge as the causing event (registered state, combinational decode).
- `overflow` is high for exactly the cycle after the dropped-write edge.
- Throughput: one write and one transfer per cycle, sustained indefinitely.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles → `tx_valid=0`, `tx_data=0`, `empty=1`, `count=0`, `overflow=0`. Then write 8'hA5 → `tx_valid` high 2 cycles later with `tx_data=8'hA5`.
- **FIFO order with stalled sink:** with `tx_ready=0`, write 8'h00..8'h10 (17 bytes) → `count=17`, `full=1`, `tx_data=8'h00` stable. Then write 8'h55 → `overflow` is a 1-cycle pulse and `count` stays 17.
- **Drain:** drain the previous fill with `tx_ready=1` continuously → `tx_data` steps 8'h00..8'h10 on 17 consecutive cycles, then `tx_valid=0` and `empty=1`. 8'h55 never appears.
- **Wrap-around:** write and drain 40 incrementing bytes through the 16-entry memory → the receive order matches exactly across both pointer wraps.
- **Simultaneous traffic:** `wr_en` and `tx_ready` high every cycle for 100 cycles after an initial 3-byte preload → `count` stays 3 and there is no overflow.
- **Reset mid-operation:** assert `rst=0` for 1 cycle with 10 bytes queued while `tx_valid && !tx_ready` → next cycle `tx_valid=0`, `count=0`. A subsequent write of 8'h3C is the first byte out.
